// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage.
//   - default values for the datapath width, reset PC and bubble encoding
//   - next-PC selection enum and the helper that resolves its priority
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    NPC_ADVANCE  = 2'd0,
    NPC_HOLD     = 2'd1,
    NPC_REDIRECT = 2'd2
  } npc_sel_e;

  // A resolved branch/jump always wins over a load-use stall: the stalled
  // instruction sits on the wrong path and is being squashed anyway.
  function automatic npc_sel_e npc_select(input logic redirect,
                                          input logic stall);
    npc_sel_e sel;
    if (redirect)   sel = NPC_REDIRECT;
    else if (stall) sel = NPC_HOLD;
    else            sel = NPC_ADVANCE;
    return sel;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// PC / instruction / valid pipeline register with hold and flush controls.
// Flush has priority over stall and loads a bubble (NOP, valid=0) while still
// capturing the PC, so the bubble carries the address of the discarded slot.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   stall              hold current contents
//   flush              replace contents with a bubble
//   fetch_pc/_instr    values presented by the upstream stage
//   pc, instr, valid   registered stage contents
// ---------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // IF -> ID boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= fetch_pc;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      pc    <= fetch_pc;
      instr <= fetch_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register,
// misaligned-redirect flag and fetched-instruction counter.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   stall                load-use hold of PC and IF/ID
//   redirect/_pc         taken branch / jump from EX and its target
//   imem_addr            byte address to instruction memory (= pc_IF)
//   imem_rdata           same-cycle instruction word from memory
//   pc_IF, instr_IF      current fetch PC and the word read there
//   pc_ID, instr_ID      contents of the IF/ID register
//   valid_ID             0 when ID holds a bubble
//   misalign             one-cycle pulse after a redirect to a non-word target
//   fetch_cnt            number of instructions accepted into ID (wraps)
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF[XLEN-1:0],
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_IF,
  output logic [31:0]     instr_IF,
  output logic [XLEN-1:0] pc_ID,
  output logic [31:0]     instr_ID,
  output logic            valid_ID,
  output logic            misalign,
  output logic [31:0]     fetch_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  npc_sel_e        sel;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target_aligned;

  // Misaligned targets are fetched from the containing word; the low bits
  // only feed the misalign report.
  assign target_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    sel     = npc_select(redirect, stall);
    pc_next = pc_p0;
    case (sel)
      NPC_REDIRECT: pc_next = target_aligned;
      NPC_HOLD:     pc_next = pc_p0;
      default:      pc_next = pc_p0 + PC_STEP;  // wraps modulo 2^XLEN
    endcase
  end

  // PC register / IF stage boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_p0     <= RESET_PC;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      pc_p0    <= pc_next;
      misalign <= (sel == NPC_REDIRECT) && (|redirect_pc[1:0]);
      if (sel == NPC_ADVANCE)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign imem_addr = pc_p0;
  assign pc_IF     = pc_p0;
  assign instr_IF  = imem_rdata;

  // A redirect discards the wrong-path word at IF by flushing instead of
  // latching it, which costs exactly one bubble in ID.
  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .flush       (redirect),
    .fetch_pc    (pc_p0),
    .fetch_instr (imem_rdata),
    .pc          (pc_ID),
    .instr       (instr_ID),
    .valid       (valid_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF, instr_IF, pc_ID, instr_ID, fetch_cnt;
  logic        valid_ID, misalign;

  // second instance exercising PC wrap-around
  logic        rstn_w;
  logic [31:0] w_addr, w_rdata, w_pc_IF, w_instr_IF, w_pc_ID, w_instr_ID, w_cnt;
  logic        w_valid, w_mis;

  logic [31:0] mem [0:255];

  assign imem_rdata = mem[imem_addr[9:2]];
  assign w_rdata    = mem[w_addr[9:2]];

  if_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_IF(pc_IF), .instr_IF(instr_IF), .pc_ID(pc_ID), .instr_ID(instr_ID),
    .valid_ID(valid_ID), .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rstn(rstn_w), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .pc_IF(w_pc_IF), .instr_IF(w_instr_IF), .pc_ID(w_pc_ID), .instr_ID(w_instr_ID),
    .valid_ID(w_valid), .misalign(w_mis), .fetch_cnt(w_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference state: what the fetch stage should hold after each edge
  logic [31:0] m_pc, m_pc_id, m_instr, m_cnt;
  logic        m_valid, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc_id = 32'h0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  // one clock: drive at the falling edge, predict the result of the next rising edge
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    exp_t e;
    logic [31:0] cur_pc;
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rpc;
    cur_pc = m_pc;
    if (r) begin
      m_pc_id = cur_pc;
      m_instr = NOP;
      m_valid = 1'b0;
      m_mis   = (rpc % 4) != 0;
      m_pc    = rpc - (rpc % 4);
    end else if (s) begin
      m_mis = 1'b0;
    end else begin
      m_pc_id = cur_pc;
      m_instr = mem[(cur_pc / 4) % 256];
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
      m_pc    = cur_pc + 4;
      m_mis   = 1'b0;
    end
    e.pc_if = m_pc; e.pc_id = m_pc_id; e.instr_id = m_instr;
    e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    check("rst_pc_IF", pc_IF, 32'h0);
    check("rst_pc_ID", pc_ID, 32'h0);
    check("rst_instr_ID", instr_ID, NOP);
    check("rst_valid_ID", {31'b0, valid_ID}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    model_reset();
    settle();
    rstn = 1'b1;
  endtask

  // monitor: compares every edge for which an expectation was queued
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pc_IF", pc_IF, e.pc_if);
      check("imem_addr", imem_addr, e.pc_if);
      check("instr_IF", instr_IF, mem[(e.pc_if / 4) % 256]);
      check("pc_ID", pc_ID, e.pc_id);
      check("instr_ID", instr_ID, e.instr_id);
      check("valid_ID", {31'b0, valid_ID}, {31'b0, e.valid});
      check("misalign", {31'b0, misalign}, {31'b0, e.mis});
      check("fetch_cnt", fetch_cnt, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int adv;
    logic reached;
    rstn = 1'b1; rstn_w = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();

    // asynchronous reset mid-cycle at t=5
    do_reset();

    // sequential fetch
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);
    settle();
    check("seq_pc_IF", pc_IF, 32'h10);
    check("seq_pc_ID", pc_ID, 32'h0C);
    check("seq_instr_ID", instr_ID, mem[3]);
    check("seq_valid_ID", {31'b0, valid_ID}, 32'h1);
    check("seq_fetch_cnt", fetch_cnt, 32'd4);

    // stall for three cycles at 0x08
    do_reset();
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
    settle();
    check("stall_pc_IF", pc_IF, 32'h08);
    check("stall_instr_ID", instr_ID, mem[1]);
    check("stall_fetch_cnt", fetch_cnt, 32'd2);
    cyc(1'b0, 1'b0, 32'h0);
    settle();
    check("resume_pc_IF", pc_IF, 32'h0C);

    // redirect from 0x14 to 0x40
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    settle();
    check("pre_redir_pc_IF", pc_IF, 32'h14);
    cyc(1'b0, 1'b1, 32'h40);
    settle();
    check("redir_pc_IF", pc_IF, 32'h40);
    check("redir_instr_ID", instr_ID, NOP);
    check("redir_valid_ID", {31'b0, valid_ID}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    settle();
    check("post_redir_instr_ID", instr_ID, mem[16]);
    check("post_redir_valid_ID", {31'b0, valid_ID}, 32'h1);

    // redirect and stall together, misaligned target
    cyc(1'b1, 1'b1, 32'h22);
    settle();
    check("rs_pc_IF", pc_IF, 32'h20);
    check("rs_valid_ID", {31'b0, valid_ID}, 32'h0);
    check("rs_misalign", {31'b0, misalign}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0);
    settle();
    check("rs_misalign_drop", {31'b0, misalign}, 32'h0);

    // back-to-back redirects
    cyc(1'b0, 1'b1, 32'h100);
    cyc(1'b0, 1'b1, 32'h207);
    settle();
    check("b2b_pc_IF", pc_IF, 32'h204);
    check("b2b_valid_ID", {31'b0, valid_ID}, 32'h0);
    check("b2b_pc_ID", pc_ID, 32'h100);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      cyc(s, r, t);
    end

    // run the program until pc_ID reaches 0x78
    do_reset();
    adv = 0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      logic s;
      s = ($urandom_range(0, 3) == 0);
      cyc(s, 1'b0, 32'h0);
      if (!s) adv++;
      settle();
      if (pc_ID == 32'h78) reached = 1'b1;
    end
    check("prog_reached_78", {31'b0, reached}, 32'h1);
    check("prog_fetch_cnt", fetch_cnt, 32'h78 / 4 + 1);
    check("prog_advances", fetch_cnt, 32'(adv));

    // PC wrap with RESET_PC = 0xFFFFFFF8
    #1;
    check("wrap_rst_pc", w_pc_IF, 32'hFFFF_FFF8);
    rstn_w = 1'b1;
    settle();
    check("wrap_pc_1", w_pc_IF, 32'hFFFF_FFFC);
    settle();
    check("wrap_pc_2", w_pc_IF, 32'h0000_0000);
    check("wrap_pc_ID", w_pc_ID, 32'hFFFF_FFFC);
    check("wrap_cnt", w_cnt, 32'd2);
    check("wrap_valid", {31'b0, w_valid}, 32'h1);

    settle();
    check("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
